// File: rtl/arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package arb_pkg;

  localparam int ARB_ADDR_WIDTH = 32;
  localparam int ARB_DATA_WIDTH = 32;
  localparam int ARB_TIMEOUT    = 255;
  localparam int CNT_WIDTH      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Wait-cycle counter: counts cycles spent waiting for the memory and flags
// when the count equals the programmed limit. Holds at the limit.
module wait_counter
  import arb_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;

  assign expired = (count_reg == limit);

  // Clear on a new transaction, otherwise count waiting cycles up to the limit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch stage and the memory
// stage. Data accesses win over fetches; each access is held on the memory
// bus until MemReady or until the wait counter times out.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int TIMEOUT    = ARB_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  InstrReqF,
  input  logic [ADDR_WIDTH-1:0] InstrAddrF,
  input  logic                  FetchKill,
  input  logic                  MemReqM,
  input  logic                  MemWriteM,
  input  logic [ADDR_WIDTH-1:0] DataAddrM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  MemReq,
  output logic                  MemWE,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWData,
  input  logic                  MemReady,
  input  logic [DATA_WIDTH-1:0] MemRData,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic                  InstrValidF,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  DataDoneM,
  output logic                  StallArbF,
  output logic                  StallArbM,
  output logic                  BusError
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT);

  arb_state_t            state_reg;
  logic                  kill_reg;
  logic                  mem_req_reg;
  logic                  mem_we_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;
  logic [DATA_WIDTH-1:0] instr_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  valid_reg;
  logic                  done_reg;
  logic                  bus_err_reg;

  logic take_data;
  logic take_instr;
  logic timed_out;

  // A request whose done/valid pulse is showing this cycle is the one just
  // served (the pipeline only advances at the end of the pulse cycle), so it
  // is not accepted a second time.
  assign take_data  = (state_reg == IDLE) && MemReqM && !done_reg;
  assign take_instr = (state_reg == IDLE) && !take_data && InstrReqF && !valid_reg;

  wait_counter #(.WIDTH(CNT_WIDTH)) u_wait_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (take_data || take_instr),
    .enable  ((state_reg != IDLE) && !MemReady),
    .limit   (LIMIT),
    .expired (timed_out)
  );

  // Arbitration FSM with registered memory-side and pipeline-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      kill_reg      <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      instr_reg     <= '0;
      rdata_reg     <= '0;
      valid_reg     <= 1'b0;
      done_reg      <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          kill_reg <= 1'b0;
          if (take_data) begin
            state_reg     <= DATA;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= MemWriteM;
            mem_addr_reg  <= DataAddrM;
            mem_wdata_reg <= WriteDataM;
          end else if (take_instr) begin
            state_reg    <= INSTR;
            mem_req_reg  <= 1'b1;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= InstrAddrF;
            kill_reg     <= FetchKill;
          end
        end
        INSTR: begin
          if (FetchKill) begin
            kill_reg <= 1'b1;
          end
          if (MemReady) begin
            // A redirect arriving with the data also discards it.
            instr_reg   <= MemRData;
            valid_reg   <= !(kill_reg || FetchKill);
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
            kill_reg    <= 1'b0;
          end else if (timed_out) begin
            bus_err_reg <= 1'b1;
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
            kill_reg    <= 1'b0;
          end
        end
        DATA: begin
          if (MemReady) begin
            if (!mem_we_reg) begin
              rdata_reg <= MemRData;
            end
            done_reg    <= 1'b1;
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
          end else if (timed_out) begin
            bus_err_reg <= 1'b1;
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          mem_req_reg <= 1'b0;
          mem_we_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign MemReq      = mem_req_reg;
  assign MemWE       = mem_we_reg;
  assign MemAddr     = mem_addr_reg;
  assign MemWData    = mem_wdata_reg;
  assign InstrF      = instr_reg;
  assign InstrValidF = valid_reg;
  assign ReadDataM   = rdata_reg;
  assign DataDoneM   = done_reg;
  assign BusError    = bus_err_reg;

  assign StallArbM = MemReqM && !done_reg;
  assign StallArbF = (InstrReqF && !valid_reg) || StallArbM;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level reference model
// checked against the DUT on every cycle, plus hand-computed literal checks.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          InstrReqF = 1'b0;
  logic [AW-1:0] InstrAddrF = '0;
  logic          FetchKill = 1'b0;
  logic          MemReqM = 1'b0;
  logic          MemWriteM = 1'b0;
  logic [AW-1:0] DataAddrM = '0;
  logic [DW-1:0] WriteDataM = '0;
  logic          MemReady = 1'b0;
  logic [DW-1:0] MemRData = '0;
  logic          MemReq, MemWE;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData, InstrF, ReadDataM;
  logic          InstrValidF, DataDoneM, StallArbF, StallArbM, BusError;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .InstrReqF(InstrReqF), .InstrAddrF(InstrAddrF), .FetchKill(FetchKill),
    .MemReqM(MemReqM), .MemWriteM(MemWriteM), .DataAddrM(DataAddrM), .WriteDataM(WriteDataM),
    .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemReady(MemReady), .MemRData(MemRData),
    .InstrF(InstrF), .InstrValidF(InstrValidF),
    .ReadDataM(ReadDataM), .DataDoneM(DataDoneM),
    .StallArbF(StallArbF), .StallArbM(StallArbM), .BusError(BusError)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one outstanding transaction) ----------
  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    int          waited;
    bit          killed;
  } txn_t;

  txn_t        cur;
  bit          m_active = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_instr = '0, m_rdata = '0;
  bit          m_valid = 0, m_done = 0, m_err = 0;
  bit          checking = 0;

  always @(posedge clk) begin : model
    bit pv, pd;
    pv = m_valid;
    pd = m_done;
    m_valid = 0;
    m_done  = 0;
    if (rst) begin
      m_active = 0; m_addr = '0; m_wdata = '0; m_instr = '0; m_rdata = '0; m_err = 0;
    end else if (m_active) begin
      if (!cur.is_data && FetchKill) cur.killed = 1;
      if (MemReady) begin
        m_active = 0;
        if (cur.is_data) begin
          if (!cur.we) m_rdata = MemRData;
          m_done = 1;
        end else begin
          m_instr = MemRData;
          m_valid = !cur.killed;
        end
      end else if (cur.waited == TO) begin
        m_active = 0;
        m_err = 1;
      end else begin
        cur.waited++;
      end
    end else if (MemReqM && !pd) begin
      cur = '{is_data: 1, we: MemWriteM, addr: DataAddrM, waited: 0, killed: 0};
      m_active = 1; m_addr = DataAddrM; m_wdata = WriteDataM;
    end else if (InstrReqF && !pv) begin
      cur = '{is_data: 0, we: 0, addr: InstrAddrF, waited: 0, killed: FetchKill};
      m_active = 1; m_addr = InstrAddrF;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("MemReq", 64'(MemReq), 64'(m_active));
      chk("MemWE", 64'(MemWE), 64'(m_active && cur.is_data && cur.we));
      chk("MemAddr", 64'(MemAddr), 64'(m_addr));
      chk("MemWData", 64'(MemWData), 64'(m_wdata));
      chk("InstrF", 64'(InstrF), 64'(m_instr));
      chk("InstrValidF", 64'(InstrValidF), 64'(m_valid));
      chk("ReadDataM", 64'(ReadDataM), 64'(m_rdata));
      chk("DataDoneM", 64'(DataDoneM), 64'(m_done));
      chk("BusError", 64'(BusError), 64'(m_err));
      chk("StallArbM", 64'(StallArbM), 64'(MemReqM && !m_done));
      chk("StallArbF", 64'(StallArbF), 64'((InstrReqF && !m_valid) || (MemReqM && !m_done)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    // reset
    tick();
    checking = 1;
    tick();
    rst = 0;
    neg();
    chk("reset_MemReq", 64'(MemReq), 64'd0);
    chk("reset_BusError", 64'(BusError), 64'd0);
    chk("reset_ReadDataM", 64'(ReadDataM), 64'd0);
    chk("reset_MemAddr", 64'(MemAddr), 64'd0);
    tick();

    // fetch only, ready two cycles after MemReq
    InstrReqF = 1; InstrAddrF = 32'h10;
    tick();
    neg();
    chk("fetch_MemAddr", 64'(MemAddr), 64'h10);
    chk("fetch_MemReq", 64'(MemReq), 64'd1);
    chk("fetch_StallF", 64'(StallArbF), 64'd1);
    tick();
    tick();
    MemReady = 1; MemRData = 32'hE3A01005;
    tick();
    MemReady = 0; InstrReqF = 0;
    neg();
    chk("fetch_Valid", 64'(InstrValidF), 64'd1);
    chk("fetch_InstrF", 64'(InstrF), 64'hE3A01005);
    tick();
    neg();
    chk("fetch_ValidPulse", 64'(InstrValidF), 64'd0);
    tick();

    // simultaneous load and fetch: data first
    MemReqM = 1; MemWriteM = 0; DataAddrM = 32'h200; InstrReqF = 1; InstrAddrF = 32'h14;
    tick();
    neg();
    chk("both_DataFirst", 64'(MemAddr), 64'h200);
    chk("both_StallF1", 64'(StallArbF), 64'd1);
    MemReady = 1; MemRData = 32'h12345678;
    tick();
    MemReady = 0; MemReqM = 0;
    neg();
    chk("both_Done", 64'(DataDoneM), 64'd1);
    chk("both_ReadData", 64'(ReadDataM), 64'h12345678);
    chk("both_StallF2", 64'(StallArbF), 64'd1);
    tick();
    neg();
    chk("both_InstrNext", 64'(MemAddr), 64'h14);
    chk("both_InstrReq", 64'(MemReq), 64'd1);
    MemReady = 1; MemRData = 32'h0000A5A5;
    tick();
    MemReady = 0; InstrReqF = 0;
    tick();

    // store
    MemReqM = 1; MemWriteM = 1; DataAddrM = 32'h40; WriteDataM = 32'hDEADBEEF;
    tick();
    neg();
    chk("store_WE", 64'(MemWE), 64'd1);
    chk("store_WData", 64'(MemWData), 64'hDEADBEEF);
    tick();
    neg();
    chk("store_WEheld", 64'(MemWE), 64'd1);
    MemReady = 1; MemRData = 32'hFFFF0000;
    tick();
    MemReady = 0; MemReqM = 0; MemWriteM = 0;
    neg();
    chk("store_Done", 64'(DataDoneM), 64'd1);
    chk("store_RDkept", 64'(ReadDataM), 64'h12345678);
    chk("store_WEoff", 64'(MemWE), 64'd0);
    tick();

    // fetch killed while in INSTR
    InstrReqF = 1; InstrAddrF = 32'h20;
    tick();
    FetchKill = 1; InstrReqF = 0;
    tick();
    FetchKill = 0; MemReady = 1; MemRData = 32'h00001111;
    tick();
    MemReady = 0;
    neg();
    chk("kill_NoValid", 64'(InstrValidF), 64'd0);
    chk("kill_Idle", 64'(MemReq), 64'd0);
    tick();

    // fetch killed in the cycle it is accepted
    InstrReqF = 1; InstrAddrF = 32'h24; FetchKill = 1;
    tick();
    InstrReqF = 0; FetchKill = 0; MemReady = 1; MemRData = 32'h00002222;
    tick();
    MemReady = 0;
    neg();
    chk("kill0_NoValid", 64'(InstrValidF), 64'd0);
    tick();

    // ready exactly when the counter reaches TIMEOUT: completes normally
    MemReqM = 1; DataAddrM = 32'h300;
    tick();
    repeat (TO) tick();
    MemReady = 1; MemRData = 32'h0000CAFE;
    tick();
    MemReady = 0; MemReqM = 0;
    neg();
    chk("edge_Done", 64'(DataDoneM), 64'd1);
    chk("edge_NoErr", 64'(BusError), 64'd0);
    chk("edge_RData", 64'(ReadDataM), 64'hCAFE);
    tick();

    // timeout: MemReady never comes
    MemReqM = 1; DataAddrM = 32'h304;
    tick();
    repeat (TO) tick();
    neg();
    chk("to_LastReq", 64'(MemReq), 64'd1);
    tick();
    MemReqM = 0;
    neg();
    chk("to_BusError", 64'(BusError), 64'd1);
    chk("to_Idle", 64'(MemReq), 64'd0);
    chk("to_NoDone", 64'(DataDoneM), 64'd0);
    tick();
    MemReady = 1; MemRData = 32'h00005555;
    tick();
    MemReady = 0;
    neg();
    chk("idleReady_Ignored", 64'(DataDoneM), 64'd0);
    tick();
    InstrReqF = 1; InstrAddrF = 32'h30;
    tick();
    MemReady = 1; MemRData = 32'h00000077;
    tick();
    MemReady = 0; InstrReqF = 0;
    neg();
    chk("afterErr_Valid", 64'(InstrValidF), 64'd1);
    chk("afterErr_Sticky", 64'(BusError), 64'd1);
    tick();

    // reset in the middle of a data access
    MemReqM = 1; DataAddrM = 32'h400;
    tick();
    rst = 1; MemReqM = 0;
    tick();
    rst = 0; MemReady = 1; MemRData = 32'h00000099;
    neg();
    chk("rst_MemReq", 64'(MemReq), 64'd0);
    chk("rst_BusError", 64'(BusError), 64'd0);
    chk("rst_InstrF", 64'(InstrF), 64'd0);
    chk("rst_MemAddr", 64'(MemAddr), 64'd0);
    tick();
    MemReady = 0;
    neg();
    chk("rst_NoDone", 64'(DataDoneM), 64'd0);
    chk("rst_ReadData", 64'(ReadDataM), 64'd0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
